// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    RUN,
    IMM,
    RET_WAIT,
    INT_SAVE,
    INT_JUMP
  } fetch_seq_state_t;

  localparam int INT_CNT_W = 4;

endpackage

// File: rtl/int_edge_latch.sv
// Captures a rising edge of the level interrupt into a pending flag that
// stays set until the sequencer consumes it.
module int_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq_i,
  input  logic clear_i,
  output logic pending_o
);

  logic irq_q;
  logic pending_q, pending_d;

  // Clear wins over a simultaneous edge: that edge merges into the one being serviced.
  always_comb begin
    pending_d = pending_q;
    if (clear_i) begin
      pending_d = 1'b0;
    end else if (irq_i && !irq_q) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: PC redirect arbitration, two-word/stall sequencing and
// interrupt entry. Interrupt path is built only when FETCH_SEQ_INT_EN is defined.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR      = 32'h0000_0000,
  parameter int unsigned INT_SAVE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_use_hazard,
  input  logic        is_two_word,
  input  logic        ret_in_flight,
  input  logic        ret_valid,
  input  logic [31:0] ret_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        interrupt,
  input  logic [31:0] pc_plus_one_r,
  output logic        pc_write,
  output logic [31:0] pc_write_back_value,
  output logic        stall_fetch,
  output logic        clear_instruction,
  output logic        int_ack,
  output logic [31:0] int_return_addr
);

  fetch_seq_state_t state_q, state_d;

`ifdef FETCH_SEQ_INT_EN
  logic                 int_pending, int_clr;
  logic [INT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          ira_q, ira_d;

  int_edge_latch u_int_edge_latch (
    .clk       (clk),
    .reset     (reset),
    .irq_i     (interrupt),
    .clear_i   (int_clr),
    .pending_o (int_pending)
  );
`else
  logic unused_pending;
  logic unused_int;

  int_edge_latch u_int_edge_latch (
    .clk       (clk),
    .reset     (reset),
    .irq_i     (1'b0),
    .clear_i   (1'b0),
    .pending_o (unused_pending)
  );

  assign unused_int = ^{interrupt, pc_plus_one_r, INT_VECTOR, INT_SAVE_CYCLES};
`endif

  always_comb begin
    pc_write            = 1'b0;
    pc_write_back_value = '0;
    stall_fetch         = 1'b0;
    clear_instruction   = 1'b0;
    int_ack             = 1'b0;
    state_d             = state_q;
`ifdef FETCH_SEQ_INT_EN
    int_clr = 1'b0;
    cnt_d   = cnt_q;
    ira_d   = ira_q;
`endif
    // Interrupt entry/jump states are atomic: redirects there are ignored.
    if (ret_valid && (state_q inside {RUN, IMM, RET_WAIT})) begin
      pc_write            = 1'b1;
      pc_write_back_value = ret_target;
      clear_instruction   = 1'b1;
      state_d             = RUN;
    end else if (branch_taken && (state_q inside {RUN, IMM, RET_WAIT})) begin
      pc_write            = 1'b1;
      pc_write_back_value = branch_target;
      clear_instruction   = 1'b1;
      state_d             = RUN;
    end else begin
      case (state_q)
        RUN: begin
`ifdef FETCH_SEQ_INT_EN
          if (int_pending && !is_two_word) begin
            stall_fetch       = 1'b1;
            clear_instruction = 1'b1;
            int_ack           = 1'b1;
            ira_d             = pc_plus_one_r - 32'd1;
            cnt_d             = INT_CNT_W'(INT_SAVE_CYCLES - 1);
            state_d           = INT_SAVE;
          end else
`endif
          if (ret_in_flight) begin
            stall_fetch       = 1'b1;
            clear_instruction = 1'b1;
            state_d           = RET_WAIT;
          end else if (load_use_hazard) begin
            stall_fetch = 1'b1;
          end else if (is_two_word) begin
            state_d = IMM;
          end
        end
        IMM: begin
          clear_instruction = 1'b1;
          state_d           = RUN;
        end
        RET_WAIT: begin
          stall_fetch       = 1'b1;
          clear_instruction = 1'b1;
        end
`ifdef FETCH_SEQ_INT_EN
        INT_SAVE: begin
          stall_fetch       = 1'b1;
          clear_instruction = 1'b1;
          if (branch_taken) begin
            ira_d = branch_target;
          end
          if (cnt_q == '0) begin
            state_d = INT_JUMP;
          end else begin
            cnt_d = cnt_q - INT_CNT_W'(1);
          end
        end
        INT_JUMP: begin
          pc_write            = 1'b1;
          pc_write_back_value = INT_VECTOR;
          clear_instruction   = 1'b1;
          int_clr             = 1'b1;
          state_d             = RUN;
        end
`endif
        default: state_d = RUN;
      endcase
    end
    if (!reset) begin
      pc_write            = 1'b0;
      pc_write_back_value = '0;
      stall_fetch         = 1'b0;
      clear_instruction   = 1'b0;
      int_ack             = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef FETCH_SEQ_INT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ira_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ira_q <= ira_d;
    end
  end

  assign int_return_addr = ira_q;
`else
  assign int_return_addr = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; interrupt scenarios follow FETCH_SEQ_INT_EN.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load_use_hazard, is_two_word, ret_in_flight, ret_valid;
  logic        branch_taken, interrupt;
  logic [31:0] ret_target, branch_target, pc_plus_one_r;
  logic        pc_write, stall_fetch, clear_instruction, int_ack;
  logic [31:0] pc_write_back_value, int_return_addr;
  logic [3:0]  fl;

  int errors = 0;
  int checks = 0;

  assign fl = {pc_write, stall_fetch, clear_instruction, int_ack};

  fetch_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .load_use_hazard     (load_use_hazard),
    .is_two_word         (is_two_word),
    .ret_in_flight       (ret_in_flight),
    .ret_valid           (ret_valid),
    .ret_target          (ret_target),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .interrupt           (interrupt),
    .pc_plus_one_r       (pc_plus_one_r),
    .pc_write            (pc_write),
    .pc_write_back_value (pc_write_back_value),
    .stall_fetch         (stall_fetch),
    .clear_instruction   (clear_instruction),
    .int_ack             (int_ack),
    .int_return_addr     (int_return_addr)
  );

  task automatic clear_inputs;
    load_use_hazard = 1'b0;
    is_two_word     = 1'b0;
    ret_in_flight   = 1'b0;
    ret_valid       = 1'b0;
    branch_taken    = 1'b0;
    ret_target      = 32'h0;
    branch_target   = 32'h0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    interrupt = 1'b0;
    pc_plus_one_r = 32'h0;
    clear_inputs();
    ret_valid = 1'b1; ret_target = 32'h1111_2222;
    branch_taken = 1'b1; branch_target = 32'h3333_4444;
    #2;
    checks++; if (fl !== 4'b0000 || pc_write_back_value !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: flags got %b val %h want 0000 val 0", fl, pc_write_back_value);
    end
    tick(); tick();
    clear_inputs();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #4;
      checks++; if (fl !== 4'b0000 || pc_write_back_value !== 32'h0) begin
        errors++; $display("FAIL idle_%0d: flags got %b val %h want 0000 val 0", i, fl, pc_write_back_value);
      end
      checks++; if (int_return_addr !== 32'h0) begin
        errors++; $display("FAIL idle_ira_%0d: got %h want 0", i, int_return_addr);
      end
      tick();
    end
  endtask

  task automatic test_load_use;
    load_use_hazard = 1'b1;
    #4;
    checks++; if (fl !== 4'b0100) begin
      errors++; $display("FAIL load_use_stall: flags got %b want 0100", fl);
    end
    tick();
    load_use_hazard = 1'b0;
    #4;
    checks++; if (fl !== 4'b0000) begin
      errors++; $display("FAIL load_use_release: flags got %b want 0000", fl);
    end
    tick();
  endtask

  task automatic test_two_word;
    pc_plus_one_r = 32'h0;
    is_two_word = 1'b1;
    interrupt = 1'b1;
    #4;
    checks++; if (fl !== 4'b0000) begin
      errors++; $display("FAIL two_word_opcode: flags got %b want 0000", fl);
    end
    tick();
    is_two_word = 1'b0;
    #4;
    checks++; if (fl !== 4'b0010) begin
      errors++; $display("FAIL two_word_imm: flags got %b want 0010", fl);
    end
    tick();
`ifdef FETCH_SEQ_INT_EN
    #4;
    checks++; if (fl !== 4'b0111) begin
      errors++; $display("FAIL deferred_ack: flags got %b want 0111", fl);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      #4;
      checks++; if (fl !== 4'b0110 || int_return_addr !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL int_save_%0d: flags %b ira %h want 0110 ira ffffffff", i, fl, int_return_addr);
      end
      tick();
    end
    #4;
    checks++; if (fl !== 4'b1010 || pc_write_back_value !== 32'h0) begin
      errors++; $display("FAIL int_jump: flags %b val %h want 1010 val 0", fl, pc_write_back_value);
    end
    tick();
    #4;
    checks++; if (fl !== 4'b0000) begin
      errors++; $display("FAIL after_jump: flags got %b want 0000", fl);
    end
    tick();
`else
    #4;
    checks++; if (fl !== 4'b0000 || int_return_addr !== 32'h0) begin
      errors++; $display("FAIL int_ignored: flags %b ira %h want 0000 ira 0", fl, int_return_addr);
    end
    tick();
`endif
    interrupt = 1'b0;
    tick();
  endtask

  task automatic test_ret;
    ret_in_flight = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++; if (fl !== 4'b0110) begin
        errors++; $display("FAIL ret_wait_%0d: flags got %b want 0110", i, fl);
      end
      tick();
    end
    ret_in_flight = 1'b0;
    ret_valid = 1'b1; ret_target = 32'h0000_0123;
    #4;
    checks++; if (fl !== 4'b1010 || pc_write_back_value !== 32'h0000_0123) begin
      errors++; $display("FAIL ret_write: flags %b val %h want 1010 val 00000123", fl, pc_write_back_value);
    end
    tick();
    clear_inputs();
    #4;
    checks++; if (fl !== 4'b0000) begin
      errors++; $display("FAIL ret_back_to_run: flags got %b want 0000", fl);
    end
    tick();
  endtask

  task automatic test_branch;
    branch_taken = 1'b1; branch_target = 32'h0000_ABCD;
    is_two_word = 1'b1; load_use_hazard = 1'b1;
    #4;
    checks++; if (fl !== 4'b1010 || pc_write_back_value !== 32'h0000_ABCD) begin
      errors++; $display("FAIL branch_write: flags %b val %h want 1010 val 0000abcd", fl, pc_write_back_value);
    end
    tick();
    clear_inputs();
    #4;
    checks++; if (fl !== 4'b0000) begin
      errors++; $display("FAIL branch_no_imm: flags got %b want 0000", fl);
    end
    tick();
    ret_valid = 1'b1; ret_target = 32'h0000_0077;
    branch_taken = 1'b1; branch_target = 32'h0000_0099;
    #4;
    checks++; if (fl !== 4'b1010 || pc_write_back_value !== 32'h0000_0077) begin
      errors++; $display("FAIL ret_over_branch_run: flags %b val %h want 1010 val 00000077", fl, pc_write_back_value);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_ret_branch_priority;
    ret_in_flight = 1'b1;
    tick();
    ret_in_flight = 1'b0;
    ret_valid = 1'b1; ret_target = 32'h0000_0200;
    branch_taken = 1'b1; branch_target = 32'h0000_0300;
    #4;
    checks++; if (fl !== 4'b1010 || pc_write_back_value !== 32'h0000_0200) begin
      errors++; $display("FAIL ret_over_branch_wait: flags %b val %h want 1010 val 00000200", fl, pc_write_back_value);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_interrupt;
    pc_plus_one_r = 32'h0000_0041;
    interrupt = 1'b1;
    tick();
`ifdef FETCH_SEQ_INT_EN
    #4;
    checks++; if (fl !== 4'b0111) begin
      errors++; $display("FAIL int_ack: flags got %b want 0111", fl);
    end
    tick();
    branch_taken = 1'b1; branch_target = 32'h0000_0050;
    #4;
    checks++; if (fl !== 4'b0110 || int_return_addr !== 32'h0000_0040) begin
      errors++; $display("FAIL save_branch: flags %b ira %h want 0110 ira 00000040", fl, int_return_addr);
    end
    tick();
    clear_inputs();
    ret_valid = 1'b1; ret_target = 32'h0000_0999;
    #4;
    checks++; if (fl !== 4'b0110 || int_return_addr !== 32'h0000_0050) begin
      errors++; $display("FAIL save_ret_ignored: flags %b ira %h want 0110 ira 00000050", fl, int_return_addr);
    end
    tick();
    clear_inputs();
    #4;
    checks++; if (fl !== 4'b1010 || pc_write_back_value !== 32'h0) begin
      errors++; $display("FAIL vector_write: flags %b val %h want 1010 val 0", fl, pc_write_back_value);
    end
    tick();
`else
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++; if (fl !== 4'b0000 || int_return_addr !== 32'h0) begin
        errors++; $display("FAIL int_disabled_%0d: flags %b ira %h want 0000 ira 0", i, fl, int_return_addr);
      end
      tick();
    end
`endif
    interrupt = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    ret_in_flight = 1'b1;
    tick();
    ret_in_flight = 1'b0;
    #4;
    checks++; if (fl !== 4'b0110) begin
      errors++; $display("FAIL pre_reset_wait: flags got %b want 0110", fl);
    end
    #1 reset = 1'b0;
    #1;
    checks++; if (fl !== 4'b0000) begin
      errors++; $display("FAIL async_reset: flags got %b want 0000", fl);
    end
    tick();
    reset = 1'b1;
    #4;
    checks++; if (fl !== 4'b0000) begin
      errors++; $display("FAIL reset_to_run: flags got %b want 0000", fl);
    end
    tick();
`ifdef FETCH_SEQ_INT_EN
    pc_plus_one_r = 32'h0000_0010;
    interrupt = 1'b1;
    tick();
    tick();
    #2 reset = 1'b0;
    interrupt = 1'b0;
    #1;
    checks++; if (fl !== 4'b0000) begin
      errors++; $display("FAIL reset_in_save: flags got %b want 0000", fl);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      checks++; if (fl !== 4'b0000 || int_return_addr !== 32'h0) begin
        errors++; $display("FAIL no_vector_%0d: flags %b ira %h want 0000 ira 0", i, fl, int_return_addr);
      end
      tick();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_two_word();
    test_ret();
    test_branch();
    test_ret_branch_priority();
    test_interrupt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control block that sequences the fetch stage. Drives its `pc_write`, `pc_write_back_value`, `stall_fetch` and `clear_instruction` inputs.
- Arbitrates the PC redirect sources: execute-stage branch, memory-stage RET/RTI return address, and the interrupt vector.
- Sequences two-word (immediate) instructions, load-use stalls and the multi-cycle interrupt entry.
- Sits between the decode/hazard unit and the fetch stage.

Parameters:
- INT_VECTOR, 32'h0000_0000, PC loaded on interrupt entry.
- INT_SAVE_CYCLES, 2, cycles fetch is frozen while the PC/flags are pushed (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_use_hazard  in  1  decode requests a one-cycle fetch hold.
- is_two_word  in  1  current `instruction_r` is an opcode followed by an immediate word.
- ret_in_flight  in  1  RET/RTI decoded; fetch must wait for the return address.
- ret_valid  in  1  memory stage presents the return address.
- ret_target  in  32  return address.
- branch_taken  in  1  execute stage resolved a taken branch/jump.
- branch_target  in  32  branch destination.
- interrupt  in  1  external interrupt, level; rising edge is captured.
- pc_plus_one_r  in  32  registered PC+1 of the instruction in `instruction_r`.
- pc_write  out  1  load the PC with `pc_write_back_value`.
- pc_write_back_value  out  32  redirect PC.
- stall_fetch  out  1  hold the fetch pipeline registers.
- clear_instruction  out  1  replace the fetched instruction with NOP.
- int_ack  out  1  one-cycle pulse on interrupt acceptance.
- int_return_addr  out  32  address to push as the interrupt return PC (registered).

Behaviour:
- Outputs are Mealy (combinational from state + inputs), except `int_return_addr`, the state and the counter.
- Reset (`reset`=0, async): state=RUN, int_pending=0, counter=0, `int_return_addr`=0, interrupt edge register=0. All outputs 0 while in reset. Reset mid-sequence abandons the sequence; a pending interrupt is lost.
- Interrupt capture: int_pending is set on a registered rising edge of `interrupt` and cleared only in INT_JUMP. A further edge while pending is merged.
- Global priority every cycle: ret_valid > branch_taken > state action.
  - ret_valid: `pc_write`=1, value=`ret_target`, `clear_instruction`=1, next=RUN. Honoured in any state except INT_SAVE and INT_JUMP; there it is a protocol error and is ignored.
  - branch_taken (RUN, IMM, RET_WAIT): `pc_write`=1, value=`branch_target`, clear=1, next=RUN.
  - branch_taken in INT_SAVE: no `pc_write`; `int_return_addr` ← `branch_target`.
- RUN, remaining priority:
  1. int_pending and !is_two_word: `stall_fetch`=1, clear=1, `int_ack`=1, `int_return_addr` ← `pc_plus_one_r`−1 (32-bit wrap), counter ← INT_SAVE_CYCLES−1, next=INT_SAVE.
  2. ret_in_flight: stall=1, clear=1, next=RET_WAIT.
  3. load_use_hazard: stall=1 for this cycle only, stay RUN.
  4. is_two_word: no stall, next=IMM.
  5. Otherwise all outputs 0.
- IMM: clear=1 (immediate word must not decode as an opcode). Interrupts are blocked. Next=RUN.
- RET_WAIT: stall=1, clear=1 until ret_valid. Interrupts are blocked.
- INT_SAVE: stall=1, clear=1. Counter decrements each cycle; at 0, next=INT_JUMP. With INT_SAVE_CYCLES=1, exactly one INT_SAVE cycle.
- INT_JUMP: `pc_write`=1, value=INT_VECTOR, clear=1, int_pending←0, next=RUN. Total latency from `int_ack` to vector write is INT_SAVE_CYCLES+1 cycles.
- When `pc_write`=0, `pc_write_back_value` is 0.

Optional Feature:
- Macro FETCH_SEQ_INT_EN.
- Defined: interrupt path as specified.
- Undefined:
  - INT_SAVE and INT_JUMP states are not built.
  - `interrupt` is ignored.
  - `int_ack`=0 and `int_return_addr`=0 constantly; the ports remain present.
  - INT_VECTOR and INT_SAVE_CYCLES are unused.

Decomposition:
- Package fetch_seq_pkg holds:
  - the state enum `fetch_seq_state_t` {RUN, IMM, RET_WAIT, INT_SAVE, INT_JUMP};
  - the counter width constant `INT_CNT_W`=4.
- One sub-module: int_edge_latch, which covers edge detect, the pending flag and the clear input. Same async active-low reset.

Test Plan:
- Reset released, no requests for 5 cycles → all outputs 0, state RUN.
- load_use_hazard high 1 cycle → `stall_fetch`=1 that cycle only; `pc_write`=0, clear=0.
- is_two_word=1 in RUN, then interrupt edge in that same cycle → IMM with clear=1 next cycle. `int_ack` is deferred to the following RUN cycle; INT_SAVE lasts 2 cycles, then `pc_write`=1 with value 0x0.
- ret_in_flight=1, ret_valid=1 three cycles later with `ret_target`=0x0000_0123 → stall=1 and clear=1 for 3 cycles, then `pc_write`=1 with value 0x123, state RUN.
- Interrupt with `pc_plus_one_r`=0x0000_0041, then branch_taken with target 0x50 during INT_SAVE → `int_return_addr` goes 0x40 then 0x50. No `pc_write` until INT_JUMP, which writes 0x0.
- ret_valid and branch_taken asserted together in RET_WAIT → value=`ret_target`. Reset asserted mid-INT_SAVE → immediate RUN, int_pending=0, no vector write after release.
